dual_response_checker: RTL and testbench

DUAL_RESPONSE_CHECKER -- requirements
Module: dual_response_checker

---
 rtl/dual_response_checker_if.sv | 28 ++
 rtl/dual_response_checker.sv | 123 ++++++++++++
 tb/tb_dual_response_checker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_response_checker_if.sv
// Bundle of the stimulus, the two observed outputs and the measurement report.
// There is no valid/ready pair here: done is the sole qualifier and marks the one cycle in which delay1/delay2/diff/err1/err2 are freshly reported; aborted is an independent one-cycle pulse.
interface dual_response_checker_if #(
  parameter int CW = 6
);
  logic [2:0]    abc;
  logic          w1;
  logic          w2;
  logic          busy;
  logic          done;
  logic [CW-1:0] delay1;
  logic [CW-1:0] delay2;
  logic [CW-1:0] diff;
  logic          err1;
  logic          err2;
  logic          aborted;
  logic [1:0]    state;

  modport slave (
    input  abc, w1, w2,
    output busy, done, delay1, delay2, diff, err1, err2, aborted, state
  );

  modport master (
    output abc, w1, w2,
    input  busy, done, delay1, delay2, diff, err1, err2, aborted, state
  );
endinterface

// File: rtl/dual_response_checker.sv
// Measures how many cycles two implementations of (a & b) | c take to settle
// after each change of the stimulus vector, and reports both delays and their gap.
module dual_response_checker #(
  parameter int CW      = 6,
  parameter int TIMEOUT = 63
) (
  input logic                    clk,
  input logic                    rst,
  dual_response_checker_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;

  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [2:0]    abc_r, prev_abc;
  logic [CW-1:0] cnt1, cnt2, meas1, meas2;
  logic          set1, set2;
  logic [CW-1:0] delay1, delay2, diff;
  logic          err1, err2, done, aborted;

  logic          expv, chg, hit1, hit2, s1n, s2n, tmo, finish;
  logic [CW-1:0] r1, r2, rdiff;

  always_comb begin
    expv   = (abc_r[2] & abc_r[1]) | abc_r[0];
    chg    = (abc_r != prev_abc);
    hit1   = !set1 && (bus.w1 == expv);
    hit2   = !set2 && (bus.w2 == expv);
    s1n    = set1 | hit1;
    s2n    = set2 | hit2;
    // An unsettled output times out on the edge that would make its count reach TIMEOUT.
    tmo    = (!s1n && cnt1 == TLAST) || (!s2n && cnt2 == TLAST);
    finish = (s1n && s2n) || tmo;
    r1     = hit1 ? cnt1 : (set1 ? meas1 : TMAX);
    r2     = hit2 ? cnt2 : (set2 ? meas2 : TMAX);
    rdiff  = (r1 >= r2) ? (r1 - r2) : (r2 - r1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      abc_r    <= 3'b000;
      prev_abc <= 3'b000;
      cnt1     <= '0;
      cnt2     <= '0;
      meas1    <= '0;
      meas2    <= '0;
      set1     <= 1'b0;
      set2     <= 1'b0;
      delay1   <= '0;
      delay2   <= '0;
      diff     <= '0;
      err1     <= 1'b0;
      err2     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      abc_r   <= bus.abc;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (chg) prev_abc <= abc_r;
      case (state)
        IDLE, REPORT: begin
          if (chg) begin
            state <= MEASURE;
            cnt1  <= '0;
            cnt2  <= '0;
            set1  <= 1'b0;
            set2  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        MEASURE: begin
          if (chg) begin
            aborted <= 1'b1;
            cnt1    <= '0;
            cnt2    <= '0;
            set1    <= 1'b0;
            set2    <= 1'b0;
          end else begin
            if (hit1) begin
              set1  <= 1'b1;
              meas1 <= cnt1;
            end else if (!set1 && cnt1 != TMAX) begin
              cnt1 <= cnt1 + CW'(1);
            end
            if (hit2) begin
              set2  <= 1'b1;
              meas2 <= cnt2;
            end else if (!set2 && cnt2 != TMAX) begin
              cnt2 <= cnt2 + CW'(1);
            end
            if (finish) begin
              state  <= REPORT;
              done   <= 1'b1;
              delay1 <= r1;
              delay2 <= r2;
              diff   <= rdiff;
              err1   <= !s1n;
              err2   <= !s2n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == MEASURE);
  assign bus.done    = done;
  assign bus.delay1  = delay1;
  assign bus.delay2  = delay2;
  assign bus.diff    = diff;
  assign bus.err1    = err1;
  assign bus.err2    = err2;
  assign bus.aborted = aborted;
  assign bus.state   = state;
endmodule

// File: tb/tb_dual_response_checker.sv
// Bench for dual_response_checker: directed vector table, abort/reset sequences,
// then randomized measurements scored against a delay model.
module tb_dual_response_checker;
  localparam int CW      = 6;
  localparam int TIMEOUT = 63;
  localparam int RW      = 3 * CW + 2;

  typedef struct {
    logic [2:0]    abc;
    int            t1;
    int            t2;
    bit            glitch;
    bit            chain;
    logic [CW-1:0] d1;
    logic [CW-1:0] d2;
    logic [CW-1:0] df;
    bit            e1;
    bit            e2;
  } vec_t;

  logic clk;
  logic rst;
  dual_response_checker_if #(.CW(CW)) bus ();

  dual_response_checker #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int            n_vec;
  int            n_err;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_rep;
  vec_t          tbl[12];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic exp_of(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

  // Implementation output at measurement edge k for a settle time t.
  function automatic logic wval(input int k, input int t, input logic e, input bit glitch);
    if (k < t) return ~e;
    if (k == t) return e;
    return glitch ? ~e : e;
  endfunction

  function automatic logic [RW-1:0] model_rep(input int t1, input int t2);
    int d1, d2, df;
    bit e1, e2;
    e1 = (t1 >= TIMEOUT);
    e2 = (t2 >= TIMEOUT);
    d1 = e1 ? TIMEOUT : t1;
    d2 = e2 ? TIMEOUT : t2;
    df = (d1 > d2) ? d1 - d2 : d2 - d1;
    return {e1, e2, CW'(d1), CW'(d2), CW'(df)};
  endfunction

  function automatic logic [RW-1:0] out_rep();
    return {bus.err1, bus.err2, bus.delay1, bus.delay2, bus.diff};
  endfunction

  // driver: present a new vector and wait through its registration and detection edges
  task automatic start_change(input logic [2:0] v);
    bus.abc = v;
    @(negedge clk);
    @(negedge clk);
    chk("busy_start", bus.busy, 1);
  endtask

  // driver + scoreboard: drive both outputs per measurement edge until the report
  task automatic run_meas(input logic [2:0] tgt, input int t1, input int t2, input bit glitch,
                          input bit chain, input logic [2:0] nxt, input logic [RW-1:0] rep);
    logic          e;
    int            k_end;
    logic [RW-1:0] want;
    e = exp_of(tgt);
    k_end = (t1 >= TIMEOUT || t2 >= TIMEOUT) ? TIMEOUT - 1 : ((t1 > t2) ? t1 : t2);
    exp_q.push_back(rep);
    for (int k = 0; k <= k_end; k++) begin
      bus.w1 = wval(k, t1, e, glitch);
      bus.w2 = wval(k, t2, e, glitch);
      if (chain && k == k_end) bus.abc = nxt;
      @(negedge clk);
      chk("aborted_low", bus.aborted, 0);
      if (k < k_end) begin
        chk("done_early", bus.done, 0);
        chk("busy_meas", bus.busy, 1);
      end else begin
        chk("done", bus.done, 1);
        chk("busy_report", bus.busy, 0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          want = exp_q.pop_front();
          chk("report", out_rep(), want);
          last_rep = want;
        end
      end
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("report_hold", out_rep(), last_rep);
    chk("busy_after", bus.busy, chain);
  endtask

  initial begin
    logic [2:0] cur, nv, nx;
    bit         pend, chain, gl;
    int         t1, t2;

    n_vec = 0;
    n_err = 0;
    last_rep = '0;
    rst = 1'b1;
    bus.abc = 3'b000;
    bus.w1 = 1'b0;
    bus.w2 = 1'b0;

    tbl[0]  = '{3'b001, 12, 10, 0, 0, 6'd12, 6'd10, 6'd2,  0, 0};
    tbl[1]  = '{3'b011, 0,  0,  0, 0, 6'd0,  6'd0,  6'd0,  0, 0};
    tbl[2]  = '{3'b010, 3,  3,  0, 0, 6'd3,  6'd3,  6'd0,  0, 0};
    tbl[3]  = '{3'b110, 19, 20, 1, 0, 6'd19, 6'd20, 6'd1,  0, 0};
    tbl[4]  = '{3'b100, 1,  2,  0, 0, 6'd1,  6'd2,  6'd1,  0, 0};
    tbl[5]  = '{3'b101, 5,  99, 0, 0, 6'd5,  6'd63, 6'd58, 0, 1};
    tbl[6]  = '{3'b000, 2,  2,  0, 1, 6'd2,  6'd2,  6'd0,  0, 0};
    tbl[7]  = '{3'b011, 6,  1,  1, 0, 6'd6,  6'd1,  6'd5,  0, 0};
    tbl[8]  = '{3'b010, 70, 80, 0, 0, 6'd63, 6'd63, 6'd0,  1, 1};
    tbl[9]  = '{3'b110, 62, 0,  0, 0, 6'd62, 6'd0,  6'd62, 0, 0};
    tbl[10] = '{3'b010, 63, 0,  0, 0, 6'd63, 6'd0,  6'd63, 1, 0};
    tbl[11] = '{3'b000, 1,  1,  1, 0, 6'd1,  6'd1,  6'd0,  0, 0};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_report", out_rep(), 0);
    chk("rst_state", bus.state, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // directed table
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || !tbl[i-1].chain) start_change(tbl[i].abc);
      run_meas(tbl[i].abc, tbl[i].t1, tbl[i].t2, tbl[i].glitch, tbl[i].chain,
               (i < 11) ? tbl[i+1].abc : 3'b000,
               {tbl[i].e1, tbl[i].e2, tbl[i].d1, tbl[i].d2, tbl[i].df});
    end

    // abort: 000 -> 001, back to 000 on measurement edge 5
    bus.w1 = 1'b0;
    bus.w2 = 1'b0;
    start_change(3'b001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_pre_done", bus.done, 0);
      chk("abort_pre_busy", bus.busy, 1);
    end
    bus.abc = 3'b000;
    @(negedge clk);
    chk("abort_not_yet", bus.aborted, 0);
    chk("abort_no_done_a", bus.done, 0);
    @(negedge clk);
    chk("aborted_pulse", bus.aborted, 1);
    chk("abort_no_done_b", bus.done, 0);
    chk("abort_busy", bus.busy, 1);
    run_meas(3'b000, 4, 7, 0, 0, 3'b000, model_rep(4, 7));

    // reset in the middle of a measurement
    start_change(3'b011);
    for (int k = 0; k < 3; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_report", out_rep(), 0);
    chk("mid_rst_state", bus.state, 0);
    bus.abc = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rep = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_aborted", bus.aborted, 0);
    end

    // randomized measurements against the delay model
    cur  = 3'b000;
    nx   = 3'b000;
    pend = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend) begin
        nv = nx;
      end else begin
        do nv = 3'($urandom_range(0, 7)); while (nv == cur);
        start_change(nv);
      end
      cur = nv;
      t1 = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 75) : $urandom_range(0, 25);
      t2 = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 75) : $urandom_range(0, 25);
      gl = 1'($urandom_range(0, 1));
      chain = (i < 29) && ($urandom_range(0, 2) == 0);
      do nx = 3'($urandom_range(0, 7)); while (nx == cur);
      run_meas(cur, t1, t2, gl, chain, nx, model_rep(t1, t2));
      pend = chain;
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
